traffic_lamp_ctrl: RTL
======================

Name: traffic_lamp_ctrl

Overview:
- Downstream stage of the traffic light phase FSM: consumes its 2-bit phase code (IDLE=0, GREEN=1, YELLOW=2, RED=3) and drives the three lamp outputs.
- Adds a flashing yellow in IDLE, a per-phase dwell counter and a one-cycle phase-change strobe.
- Adds a sticky safety fault on illegal transitions or a too-short yellow; while faulted, lamps are forced to red.

Parameters:
- BLINK_DIV, 4, clock cycles per half-period of the IDLE yellow flash (>=1)
- MIN_YELLOW, 3, minimum cycles YELLOW must be held before RED is legal (>=1)
- DW_W, 8, width of dwell counter

Ports:
- clock  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous active-low reset
- state_in  input  2  phase code from upstream FSM
- fault_clr  input  1  synchronous clear of sticky fault
- lamp_r  output  1  red lamp
- lamp_y  output  1  yellow lamp
- lamp_g  output  1  green lamp
- phase_chg  output  1  one-cycle pulse, registered phase changed this edge
- dwell  output  DW_W  cycles held in current phase minus 1, saturating
- fault  output  1  sticky safety fault

Behaviour:
- Reset (rst=0, asynchronous):
  - state_q=IDLE, blink_cnt=0, blink_on=1, dwell=0, phase_chg=0, fault=0.
  - Outputs during reset: lamp_y=1, lamp_r=0, lamp_g=0.
- state_q <= state_in every edge. Lamps are a combinational decode of state_q, blink_on and fault, so there is 1 cycle of latency from state_in to lamps.
- Lamp decode, fault=0:
  - GREEN -> g only.
  - YELLOW -> y only.
  - RED -> r only.
  - IDLE -> lamp_y=blink_on, r=g=0.
- Lamp decode, fault=1: r=1, y=0, g=0, regardless of state.
- Change event: state_in != state_q at an edge.
  - At that edge: phase_chg<=1, dwell<=0.
  - If the new phase is IDLE: blink_cnt<=0, blink_on<=1.
- No change:
  - phase_chg<=0.
  - dwell<=dwell+1, saturating at 2^DW_W-1 (no wrap).
- Blink, while state_q==IDLE with no change:
  - blink_cnt increments.
  - At BLINK_DIV-1 it wraps to 0 and blink_on toggles.
  - Result: yellow is on for BLINK_DIV cycles, off for BLINK_DIV cycles, starting with on.
- Legal changes: IDLE->GREEN, GREEN->YELLOW, YELLOW->RED, any->IDLE.
- Fault events, evaluated on the change edge using pre-edge dwell:
  - Any other change, e.g. GREEN->RED, RED->GREEN, IDLE->YELLOW, IDLE->RED.
  - YELLOW->RED with dwell+1 < MIN_YELLOW.
- Fault event sets fault<=1 at that edge.
- Fault is sticky. It is cleared only by fault_clr=1 at an edge with no fault event that same edge; a simultaneous event wins and fault stays 1.
- Dwell, phase_chg and blink continue to run while faulted; only the lamps are overridden.
- A phase held forever (e.g. RED) is legal: dwell saturates, no fault.
- Reset asserted mid-phase returns all state to reset values immediately, without waiting for a clock edge.

Optional Feature:
- Macro: TRAFFIC_LAMP_TEST_EN.
- Defined: adds input port lamp_test (1 bit). While lamp_test=1, lamp_r=lamp_y=lamp_g=1 combinationally, overriding both fault and phase decode. Internal state is unaffected.
- Undefined: port absent; lamp outputs as specified above.

Test Plan:
- Release reset, hold state_in=0 for 12 cycles -> lamp_y sequence 1111 0000 1111 (BLINK_DIV=4), r=g=0, phase_chg=0, fault=0.
- state_in 0->1 (held 5 cycles) ->2 (held 3) ->3 -> lamps g, y, r each 1 cycle after input change; phase_chg pulses 3 times; dwell 0..4 during GREEN; fault=0.
- YELLOW held 2 cycles then RED (MIN_YELLOW=3):
  - fault=1 from the RED edge, lamps r only.
  - state_in=0 -> lamps stay r-only.
  - fault_clr pulse -> fault=0, next cycle yellow flash resumes.
- Direct illegal changes GREEN->RED and IDLE->YELLOW (separate runs) -> fault=1 on the change edge; fault_clr asserted on the same edge as a new fault event -> fault stays 1.
- RED held 300 cycles, DW_W=8 -> dwell reaches 255 and holds; no wrap to 0; fault=0.
- Assert rst asynchronously mid-GREEN (dwell=7, between edges) -> immediately lamp_y=1, lamp_g=0, dwell=0, fault=0.
- With TRAFFIC_LAMP_TEST_EN defined: lamp_test=1 in fault state -> all lamps 1; lamp_test=0 -> red-only again.

Source files
------------

// File: rtl/traffic_lamp_ctrl.sv
// Lamp driver downstream of the traffic phase FSM: IDLE yellow flash, dwell counter,
// phase-change strobe and sticky safety fault. Optional lamp test: TRAFFIC_LAMP_TEST_EN.

module traffic_lamp_ctrl_chk #(
    parameter int DW_W = 8
) (
    input logic            clock,
    input logic            rst,
    input logic            lamp_r,
    input logic            lamp_y,
    input logic            lamp_g,
    input logic            lamp_test,
    input logic            phase_chg,
    input logic            fault,
    input logic [DW_W-1:0] dwell
);
    // Red and green must never be lit together outside lamp test.
    a_no_red_green: assert property (@(posedge clock) disable iff (!rst)
        !lamp_test |-> !(lamp_r && lamp_g));

    a_fault_red: assert property (@(posedge clock) disable iff (!rst)
        (fault && !lamp_test) |-> (lamp_r && !lamp_y && !lamp_g));

    a_chg_dwell: assert property (@(posedge clock) disable iff (!rst)
        phase_chg |-> (dwell == '0));
endmodule

module traffic_lamp_ctrl #(
    parameter int BLINK_DIV  = 4,
    parameter int MIN_YELLOW = 3,
    parameter int DW_W       = 8
) (
    input  logic            clock,
    input  logic            rst,
    input  logic [1:0]      state_in,
    input  logic            fault_clr,
`ifdef TRAFFIC_LAMP_TEST_EN
    input  logic            lamp_test,
`endif
    output logic            lamp_r,
    output logic            lamp_y,
    output logic            lamp_g,
    output logic            phase_chg,
    output logic [DW_W-1:0] dwell,
    output logic            fault
);
    typedef enum logic [1:0] {
        PH_IDLE   = 2'd0,
        PH_GREEN  = 2'd1,
        PH_YELLOW = 2'd2,
        PH_RED    = 2'd3
    } phase_t;

    localparam int BC_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(BLINK_DIV - 1);

    phase_t            state_r;
    logic [BC_W-1:0]   blink_cnt_r;
    logic              blink_on_r;
    logic [DW_W-1:0]   dwell_r;
    logic              phase_chg_r;
    logic              fault_r;

    phase_t            state_in_s;
    logic              chg_s;
    logic              yellow_short_s;
    logic              fault_evt_s;
    logic              test_s;

    // Only forward steps of the cycle, or a drop to IDLE, are safe.
    function automatic logic legal_step(input phase_t from, input phase_t to);
        logic ok;
        ok = 1'b0;
        case (to)
            PH_IDLE:   ok = 1'b1;
            PH_GREEN:  ok = (from == PH_IDLE);
            PH_YELLOW: ok = (from == PH_GREEN);
            PH_RED:    ok = (from == PH_YELLOW);
            default:   ok = 1'b0;
        endcase
        return ok;
    endfunction

`ifdef TRAFFIC_LAMP_TEST_EN
    assign test_s = lamp_test;
`else
    assign test_s = 1'b0;
`endif

    assign state_in_s = phase_t'(state_in);

    // Change detection and fault-event qualification against the pre-edge dwell.
    always_comb begin
        chg_s          = (state_in_s != state_r);
        yellow_short_s = (state_r == PH_YELLOW) && (state_in_s == PH_RED) &&
                         ((int'(dwell_r) + 32'sd1) < MIN_YELLOW);
        fault_evt_s    = chg_s && (!legal_step(state_r, state_in_s) || yellow_short_s);
    end

    // Phase register, dwell counter, strobe, flash timer and sticky fault.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state_r     <= PH_IDLE;
            blink_cnt_r <= '0;
            blink_on_r  <= 1'b1;
            dwell_r     <= '0;
            phase_chg_r <= 1'b0;
            fault_r     <= 1'b0;
        end else begin
            state_r <= state_in_s;
            if (chg_s) begin
                phase_chg_r <= 1'b1;
                dwell_r     <= '0;
                if (state_in_s == PH_IDLE) begin
                    blink_cnt_r <= '0;
                    blink_on_r  <= 1'b1;
                end else begin
                    blink_cnt_r <= blink_cnt_r;
                    blink_on_r  <= blink_on_r;
                end
            end else begin
                phase_chg_r <= 1'b0;
                if (dwell_r != {DW_W{1'b1}}) begin
                    dwell_r <= dwell_r + DW_W'(1'b1);
                end else begin
                    dwell_r <= dwell_r;
                end
                if (state_r == PH_IDLE) begin
                    if (blink_cnt_r == BC_LAST) begin
                        blink_cnt_r <= '0;
                        blink_on_r  <= ~blink_on_r;
                    end else begin
                        blink_cnt_r <= blink_cnt_r + BC_W'(1'b1);
                        blink_on_r  <= blink_on_r;
                    end
                end else begin
                    blink_cnt_r <= blink_cnt_r;
                    blink_on_r  <= blink_on_r;
                end
            end
            // A fault event on the same edge beats a clear request.
            if (fault_evt_s) begin
                fault_r <= 1'b1;
            end else if (fault_clr) begin
                fault_r <= 1'b0;
            end else begin
                fault_r <= fault_r;
            end
        end
    end

    // Lamp decode; fault forces red, lamp test lights everything.
    always_comb begin
        lamp_r = 1'b0;
        lamp_y = 1'b0;
        lamp_g = 1'b0;
        if (test_s) begin
            lamp_r = 1'b1;
            lamp_y = 1'b1;
            lamp_g = 1'b1;
        end else if (fault_r) begin
            lamp_r = 1'b1;
        end else begin
            case (state_r)
                PH_IDLE:   lamp_y = blink_on_r;
                PH_GREEN:  lamp_g = 1'b1;
                PH_YELLOW: lamp_y = 1'b1;
                PH_RED:    lamp_r = 1'b1;
                default:   lamp_r = 1'b1;
            endcase
        end
    end

    assign phase_chg = phase_chg_r;
    assign dwell     = dwell_r;
    assign fault     = fault_r;

    traffic_lamp_ctrl_chk #(.DW_W(DW_W)) u_chk (
        .clock     (clock),
        .rst       (rst),
        .lamp_r    (lamp_r),
        .lamp_y    (lamp_y),
        .lamp_g    (lamp_g),
        .lamp_test (test_s),
        .phase_chg (phase_chg),
        .fault     (fault),
        .dwell     (dwell)
    );
endmodule
